load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/mips_mem_pkg.sv | 37 +++
 rtl/mem_lane_align.sv | 58 +++++
 rtl/load_store_unit.sv | 126 ++++++++++++
 tb/tb_load_store_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types for the data-memory load/store path: access opcodes, LSU states,
// default memory size and the alignment rule applied when a request is accepted.
package mips_mem_pkg;

  localparam int unsigned MEM_BYTES_DEFAULT = 1024;

  typedef enum logic [2:0] {
    OP_LB,
    OP_LBU,
    OP_LH,
    OP_LHU,
    OP_LW,
    OP_SB,
    OP_SH,
    OP_SW
  } mem_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RMW_READ,
    ST_RMW_WRITE,
    ST_RESP
  } lsu_state_t;

  function automatic logic misaligned(input mem_op_t op, input logic [1:0] off);
    logic res;
    res = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: res = off[0];
      OP_LW, OP_SW:         res = (off != 2'b00);
      default:              res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane handling: extracts and extends load data from a memory word,
// and merges store data into the addressed lane of a read-back word.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = '0;
    case (byte_off)
      2'd0: sel_byte = word[31:24];
      2'd1: sel_byte = word[23:16];
      2'd2: sel_byte = word[15:8];
      2'd3: sel_byte = word[7:0];
      default: sel_byte = '0;
    endcase
    sel_half = byte_off[1] ? word[15:0] : word[31:16];

    load_data = '0;
    case (op)
      OP_LB:  load_data = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU: load_data = {24'h000000, sel_byte};
      OP_LH:  load_data = {{16{sel_half[15]}}, sel_half};
      OP_LHU: load_data = {16'h0000, sel_half};
      OP_LW:  load_data = word;
      default: load_data = '0;
    endcase

    merge_data = word;
    case (op)
      OP_SB: begin
        case (byte_off)
          2'd0: merge_data[31:24] = wdata[7:0];
          2'd1: merge_data[23:16] = wdata[7:0];
          2'd2: merge_data[15:8]  = wdata[7:0];
          2'd3: merge_data[7:0]   = wdata[7:0];
          default: merge_data = word;
        endcase
      end
      OP_SH: begin
        if (byte_off[1]) merge_data[15:0]  = wdata[15:0];
        else             merge_data[31:16] = wdata[15:0];
      end
      OP_SW:   merge_data = wdata;
      default: merge_data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time against a word-wide data memory,
// with read-modify-write for byte/halfword stores and range/alignment errors.
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        mem_write_enable
);

  lsu_state_t  state;
  mem_op_t     op_in;
  mem_op_t     op_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        acc_err;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  assign op_in   = mem_op_t'(req_op);
  assign acc_err = misaligned(op_in, req_addr[1:0]) || (req_addr >= MEM_BYTES);

  mem_lane_align u_align (
    .op         (op_q),
    .byte_off   (off_q),
    .word       (mem_read_data),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Every output is a register; the SW write strobe is armed at acceptance so
  // it is high for exactly the ACCESS cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      req_ready        <= 1'b1;
      resp_valid       <= 1'b0;
      resp_rdata       <= '0;
      resp_error       <= 1'b0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      mem_write_enable <= 1'b0;
      op_q             <= OP_LB;
      off_q            <= '0;
      wdata_q          <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q      <= op_in;
            off_q     <= req_addr[1:0];
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (acc_err) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
            end else if (op_in == OP_SB || op_in == OP_SH) begin
              state       <= ST_RMW_READ;
              mem_address <= {req_addr[31:2], 2'b00};
            end else begin
              state       <= ST_ACCESS;
              mem_address <= {req_addr[31:2], 2'b00};
              if (op_in == OP_SW) begin
                mem_write_enable <= 1'b1;
                mem_write_data   <= req_wdata;
              end
            end
          end
        end
        ST_ACCESS: begin
          state            <= ST_RESP;
          resp_valid       <= 1'b1;
          resp_rdata       <= load_data;
          resp_error       <= 1'b0;
          mem_address      <= '0;
          mem_write_enable <= 1'b0;
          mem_write_data   <= '0;
        end
        ST_RMW_READ: begin
          state            <= ST_RMW_WRITE;
          mem_write_enable <= 1'b1;
          mem_write_data   <= merge_data;
        end
        ST_RMW_WRITE: begin
          state            <= ST_RESP;
          resp_valid       <= 1'b1;
          resp_rdata       <= '0;
          resp_error       <= 1'b0;
          mem_address      <= '0;
          mem_write_enable <= 1'b0;
          mem_write_data   <= '0;
        end
        ST_RESP: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: begin
          state            <= ST_IDLE;
          req_ready        <= 1'b1;
          resp_valid       <= 1'b0;
          mem_address      <= '0;
          mem_write_enable <= 1'b0;
          mem_write_data   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array reference memory, directed corner cases
// and randomized requests.
module tb_load_store_unit;
  import mips_mem_pkg::*;

  localparam int unsigned MB = 1024;
  localparam int unsigned AW = $clog2(MB);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_write_enable;

  logic [31:0] mem_words [0:MB/4-1];
  logic [7:0]  ref_bytes [0:MB-1];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_writes = 0;
  int          n_resp   = 0;
  logic [31:0] last_wr_addr = '0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(MB)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data),
    .mem_write_enable (mem_write_enable)
  );

  assign mem_read_data = mem_words[mem_address[AW-1:2]];

  function automatic logic [31:0] init_word(input int unsigned i);
    return (i * 32'h9E3779B9) ^ 32'h5A5A5A5A;
  endfunction

  // Data memory: preload, then commit writes on the falling edge.
  initial begin
    for (int unsigned i = 0; i < MB/4; i++) mem_words[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (mem_write_enable) begin
        mem_words[mem_address[AW-1:2]] = mem_write_data;
        last_wr_addr = mem_address;
        n_writes++;
      end
      if (resp_valid) n_resp++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned op_size(input logic [2:0] op);
    case (mem_op_t'(op))
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      default:              return 4;
    endcase
  endfunction

  function automatic logic is_store(input logic [2:0] op);
    return op >= 3'(OP_SB);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] base;
    base = {a[31:2], 2'b00};
    return {ref_bytes[base], ref_bytes[base+1], ref_bytes[base+2], ref_bytes[base+3]};
  endfunction

  task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] got_rdata, output logic got_err);
    int unsigned sz;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
    logic [31:0] exp_rdata;
    logic [31:0] mask;
    int          lat;
    int          w0;

    sz      = op_size(op);
    exp_err = (addr >= MB) || (addr % sz != 0);
    exp_rdata = '0;
    if (!exp_err && !is_store(op)) begin
      for (int unsigned i = 0; i < sz; i++) exp_rdata = (exp_rdata << 8) | 32'(ref_bytes[addr + i]);
      if ((op == 3'(OP_LB) || op == 3'(OP_LH)) && exp_rdata[8*sz-1]) begin
        mask = (32'h1 << (8*sz)) - 1;
        exp_rdata = exp_rdata | ~mask;
      end
    end
    if (!exp_err && is_store(op))
      for (int unsigned i = 0; i < sz; i++) ref_bytes[addr + i] = 8'(wdata >> (8*(sz-1-i)));
    exp_lat = exp_err ? 1 : ((is_store(op) && sz < 4) ? 3 : 2);
    exp_wr  = (!exp_err && is_store(op)) ? 1 : 0;

    check("ready_before_req", req_ready, 1'b1);
    w0 = n_writes;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'($urandom);
    req_op    = 3'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = n;
        break;
      end
    end
    req_valid = 1'b0;
    got_rdata = resp_rdata;
    got_err   = resp_error;
    check("latency", lat, exp_lat);
    check("resp_rdata", resp_rdata, exp_rdata);
    check("resp_error", resp_error, exp_err);
    check("write_count", n_writes - w0, exp_wr);
    if (exp_wr == 1) begin
      check("write_addr", last_wr_addr, {addr[31:2], 2'b00});
      check("mem_word", mem_words[addr[AW-1:2]], ref_word(addr));
    end
    @(negedge clk);
    check("resp_pulse_end", resp_valid, 1'b0);
    check("ready_after_resp", req_ready, 1'b1);
    check("idle_mem_address", mem_address, 32'h0);
    check("idle_mem_wdata", mem_write_data, 32'h0);
    check("resp_rdata_hold", resp_rdata, exp_rdata);
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    logic [31:0] a;
    int          w0;
    int          r0;

    rst_n = 1'b0;
    req_valid = 1'b1;
    req_op = 3'(OP_SW);
    req_addr = 32'h0;
    req_wdata = 32'hFFFFFFFF;
    for (int unsigned i = 0; i < MB/4; i++) begin
      r = init_word(i);
      ref_bytes[4*i]   = r[31:24];
      ref_bytes[4*i+1] = r[23:16];
      ref_bytes[4*i+2] = r[15:8];
      ref_bytes[4*i+3] = r[7:0];
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_error", resp_error, 1'b0);
    check("rst_mem_we", mem_write_enable, 1'b0);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_mem_wdata", mem_write_data, 32'h0);
    check("rst_no_write", n_writes, 0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    run_req(3'(OP_SW), 32'h10, 32'h8899AABB, r, e);
    run_req(3'(OP_LB), 32'h11, 32'h0, r, e);
    check("lb_0x11", r, 32'hFFFFFF99);
    run_req(3'(OP_LBU), 32'h11, 32'h0, r, e);
    check("lbu_0x11", r, 32'h00000099);
    run_req(3'(OP_SB), 32'h12, 32'h000000CC, r, e);
    check("sb_merge_word", mem_words[4], 32'h8899CCBB);
    check("sb_err", e, 1'b0);
    run_req(3'(OP_LH), 32'h13, 32'h0, r, e);
    check("lh_misaligned_err", e, 1'b1);
    check("lh_misaligned_rdata", r, 32'h0);
    run_req(3'(OP_SW), 32'h400, 32'h12345678, r, e);
    check("sw_range_err", e, 1'b1);
    run_req(3'(OP_SW), 32'h3FC, 32'hDEADBEEF, r, e);
    run_req(3'(OP_LW), 32'h3FC, 32'h0, r, e);
    check("lw_back_to_back", r, 32'hDEADBEEF);
    run_req(3'(OP_LH), 32'h12, 32'h0, r, e);
    check("lh_low_half", r, 32'hFFFFCCBB);
    run_req(3'(OP_LW), 32'h10, 32'h0, r, e);

    // Reset while an SH sits in its read phase.
    w0 = n_writes;
    r0 = n_resp;
    req_valid = 1'b1;
    req_op    = 3'(OP_SH);
    req_addr  = 32'h22;
    req_wdata = 32'h0000F00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_req_ready", req_ready, 1'b1);
    check("midrst_resp_valid", resp_valid, 1'b0);
    check("midrst_resp_rdata", resp_rdata, 32'h0);
    check("midrst_mem_we", mem_write_enable, 1'b0);
    check("midrst_mem_address", mem_address, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_no_write", n_writes - w0, 0);
    check("midrst_no_resp", n_resp - r0, 0);
    check("midrst_mem_same", mem_words[8], ref_word(32'h20));

    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 3))
        0:       a = $urandom_range(MB - 8, MB + 8);
        1:       a = $urandom;
        default: a = $urandom_range(0, MB - 1);
      endcase
      run_req(3'($urandom_range(0, 7)), a, $urandom, r, e);
    end

    for (int unsigned i = 0; i < MB/4; i++)
      if (mem_words[i] !== ref_word(32'(4*i))) check("final_mem", mem_words[i], ref_word(32'(4*i)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
